pattern_detector: RTL
=====================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1011: pattern loaded at reset; MSB is the first bit received.
REQ-003 Parameter FSM_MEALY, default 1: 1 = Mealy output, 0 = Moore output.
REQ-004 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-005 Parameter CNT_W, default 8: match counter width; legal range 1..32.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 din  input  1  serial data bit.
REQ-009 din_valid  input  1  din is accepted on a rising clk edge only when this is high.
REQ-010 pat_load  input  1  loads pat_in as the active pattern.
REQ-011 pat_in  input  PAT_W  new pattern; MSB is compared against the oldest bit.
REQ-012 clr_cnt  input  1  synchronous clear of the match counter.
REQ-013 match  output  1  pattern-detected pulse.
REQ-014 match_cnt  output  CNT_W  number of detected matches, saturating.
REQ-015 cnt_sat  output  1  high while match_cnt is all-ones.

Function
REQ-016 The block SHALL keep a PAT_W-1-bit history shift register and a fill count 0..PAT_W-1; each accepted bit shifts in at the LSB, and the fill count increments, saturating at PAT_W-1.
REQ-017 A match event SHALL occur when din_valid=1, fill count = PAT_W-1, pat_load=0, and {history, din} equals the active pattern.
REQ-018 With FSM_MEALY=1, match SHALL be the combinational match-event condition and be asserted in the same cycle the final bit is presented.
REQ-019 With FSM_MEALY=0, match SHALL be a register set to the match-event value at each rising edge; it is high for exactly one cycle after each event and low otherwise.
REQ-020 With OVERLAP=1, history and fill SHALL be kept after an event, so pattern 1111 on input 111111 gives 3 events.
REQ-021 With OVERLAP=0, fill SHALL go to 0 on the edge that accepts an event, so the next event needs PAT_W new bits.
REQ-022 Idle cycles (din_valid=0) SHALL leave history, fill and counter unchanged; in Mealy mode match SHALL be 0 in these cycles.
REQ-023 pat_load=1 at an edge SHALL load pat_in into the pattern register and set fill to 0; a din presented in the same cycle is discarded, and no event occurs in that cycle.
REQ-024 match_cnt SHALL increment by 1 on each event edge and hold at 2^CNT_W-1 when saturated; cnt_sat is the combinational decode of all-ones.
REQ-025 When clr_cnt and an event occur in the same cycle, clr_cnt SHALL win and match_cnt SHALL become 0.

Reset
REQ-026 rst_n=0 SHALL asynchronously set history=0, fill=0, pattern=PATTERN, registered match=0, match_cnt=0 and cnt_sat=0.
REQ-027 Reset asserted in the middle of a partial pattern SHALL discard it; after release, a full PAT_W bits are required before the next event.

Configuration
REQ-028 With macro PATTERN_DETECTOR_CNT_EN defined, the match counter SHALL be built as in REQ-024 and REQ-025.
REQ-029 Without PATTERN_DETECTOR_CNT_EN, no counter flops SHALL exist, match_cnt SHALL be tied to 0, cnt_sat tied to 0, and clr_cnt ignored.

Verification
REQ-030 Defaults, counter enabled, stream 101011011001011 with din_valid=1 -> match during bits 6, 9 and 15; match_cnt=3.
REQ-031 Pattern 1111 (loaded via pat_load), stream 111111: OVERLAP=1 -> events at bits 4, 5 and 6 (cnt=3); OVERLAP=0 -> event at bit 4 only (cnt=1).
REQ-032 FSM_MEALY=0, stream 1011 -> match low during bit 4, high for exactly one cycle after the bit-4 edge, then low.
REQ-033 Send 101, pulse pat_load with pat_in=0110 while din=1, then send 0110 -> no match for the first stream, match on the final 0 of 0110.
REQ-034 CNT_W=2 with 5 events -> match_cnt sequence 1, 2, 3, 3, 3 and cnt_sat=1 from the third event; clr_cnt asserted together with an event -> match_cnt=0.
REQ-035 Send 101, assert rst_n=0 between clock edges, release it, then send 1 -> match and match_cnt low immediately at reset and no event afterwards; sending a further 011 gives a match.

Source files
------------

// File: rtl/pattern_detector.sv
`timescale 1ns/1ps
// pattern_detector: serial bit-pattern detector with a loadable pattern, Mealy/Moore output and overlap control.
// The saturating match counter is built only when the macro PATTERN_DETECTOR_CNT_EN is defined.
module pattern_detector #(
  parameter int unsigned      PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
  parameter int unsigned      FSM_MEALY = 1,
  parameter int unsigned      OVERLAP   = 1,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned       FILL_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [PAT_W-2:0]  HIST_ZERO = {(PAT_W-1){1'b0}};

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_window;
  logic              w_full;
  logic              w_accept;
  logic              w_event;

  // The candidate window is the stored history with the bit currently on din appended.
  assign w_window = {r_hist, din};
  assign w_full   = (r_fill == FILL_FULL);
  assign w_accept = din_valid & ~pat_load;
  assign w_event  = w_accept & w_full & (w_window == r_pat);

  // Pattern register, history shift register and fill count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat  <= PATTERN;
      r_hist <= HIST_ZERO;
      r_fill <= FILL_ZERO;
    end else if (pat_load) begin
      r_pat  <= pat_in;
      r_fill <= FILL_ZERO;
    end else if (din_valid) begin
      r_hist <= w_window[PAT_W-2:0];
      if (w_event && (OVERLAP == 0)) begin
        r_fill <= FILL_ZERO;
      end else if (!w_full) begin
        r_fill <= r_fill + FILL_ONE;
      end else begin
        r_fill <= r_fill;
      end
    end else begin
      r_hist <= r_hist;
      r_fill <= r_fill;
    end
  end

  generate
    if (FSM_MEALY != 0) begin : g_mealy
      assign match = w_event;
    end else begin : g_moore
      logic r_match;

      // Moore output: one-cycle pulse following each event edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_match <= 1'b0;
        end else begin
          r_match <= w_event;
        end
      end

      assign match = r_match;
    end
  endgenerate

`ifdef PATTERN_DETECTOR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_sat;

  assign w_cnt_sat = &r_cnt;

  // Saturating match counter; a clear in the same cycle as an event takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (clr_cnt) begin
      r_cnt <= CNT_ZERO;
    end else if (w_event && !w_cnt_sat) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign match_cnt = r_cnt;
  assign cnt_sat   = w_cnt_sat;
`else
  logic w_unused_clr;

  assign w_unused_clr = clr_cnt;
  assign match_cnt    = {CNT_W{1'b0}};
  assign cnt_sat      = 1'b0;
`endif

endmodule
